// File: rtl/std_dev_stream_if.sv
// rtl/std_dev_stream_if.sv - sample-in / result-out handshake bundle for std_dev_stream
// mean_out exists only when STD_DEV_MEAN_OUT_EN is defined.
interface std_dev_stream_if #(
  parameter int SIZE = 32
);
  logic [SIZE-1:0] in_data;
  logic            in_valid;
  logic            in_ready;
  logic [SIZE-1:0] std_dev;
  logic            out_valid;
  logic            out_ready;
`ifdef STD_DEV_MEAN_OUT_EN
  logic [SIZE-1:0] mean_out;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, std_dev, out_valid, mean_out
  );
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, std_dev, out_valid, mean_out
  );
`else
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, std_dev, out_valid
  );
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, std_dev, out_valid
  );
`endif
endinterface

// File: rtl/std_dev_stream.sv
// rtl/std_dev_stream.sv - streaming population standard deviation over N_INPUT samples
// Optional registered mean output enabled by STD_DEV_MEAN_OUT_EN.
module std_dev_stream #(
  parameter int N_INPUT = 8,
  parameter int SIZE    = 32
) (
  input  logic              clk,
  input  logic              reset,
  std_dev_stream_if.slave   st
);
  localparam int LG = $clog2(N_INPUT);
  localparam int SW = SIZE + LG;
  localparam int QW = 2 * SIZE + LG;
  localparam int DW = 2 * SIZE + 2 * LG;
  localparam int VW = 2 * SIZE;
  localparam int IW = $clog2(SIZE);
  localparam logic [LG-1:0] CNT_LAST  = LG'(N_INPUT - 1);
  localparam logic [IW-1:0] ITER_LAST = IW'(SIZE - 1);

  typedef enum logic [1:0] {ACCUM, CALC, SQRT, DONE} state_t;

  state_t          state, next_state;
  logic [LG-1:0]   cnt;
  logic [SW-1:0]   sum;
  logic [QW-1:0]   sumsq;
  logic [VW-1:0]   variance;
  logic [SIZE+1:0] rem;
  logic [SIZE-1:0] root;
  logic [IW-1:0]   iter;
  logic [SIZE-1:0] std_dev_q;
  logic            out_valid_q;
  logic            in_ready_c;
  logic            accept;
  logic            last_accept;
  logic            take;

  logic [DW-1:0]   sum_ext;
  logic [DW-1:0]   d_full;
  logic [VW-1:0]   var_next;
  logic [SIZE+3:0] rem_t;
  logic [SIZE+1:0] trial;
  logic [SIZE+1:0] rem_diff;
  logic [SIZE+1:0] rem_next;
  logic [SIZE-1:0] root_next;
  logic            sq_ge;

  assign accept      = st.in_valid && in_ready_c;
  assign last_accept = accept && (cnt == CNT_LAST);
  assign take        = out_valid_q && st.out_ready;

  // D = N*sumsq - sum^2 at full width; floor(D / N^2) is the exact floored variance
  assign sum_ext  = DW'(sum);
  assign d_full   = (DW'(sumsq) << LG) - sum_ext * sum_ext;
  assign var_next = VW'(d_full >> (2 * LG));

  // One restoring root step: bring down two radicand bits, try subtracting 4*root+1
  always_comb begin
    rem_t     = {rem, variance[VW-1 -: 2]};
    trial     = {root, 2'b01};
    sq_ge     = (rem_t >= {2'b00, trial});
    rem_diff  = rem_t[SIZE+1:0] - trial;
    rem_next  = sq_ge ? rem_diff : rem_t[SIZE+1:0];
    root_next = {root[SIZE-2:0], sq_ge};
  end

  always_comb begin
    next_state = state;
    in_ready_c = 1'b0;
    case (state)
      ACCUM: begin
        in_ready_c = 1'b1;
        if (last_accept) next_state = CALC;
      end
      CALC: next_state = SQRT;
      SQRT: if (iter == ITER_LAST) next_state = DONE;
      DONE: if (take) next_state = ACCUM;
      default: next_state = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ACCUM;
      cnt         <= '0;
      sum         <= '0;
      sumsq       <= '0;
      variance    <= '0;
      rem         <= '0;
      root        <= '0;
      iter        <= '0;
      std_dev_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state <= next_state;
      case (state)
        ACCUM: begin
          if (accept) begin
            sum   <= sum + SW'(st.in_data);
            sumsq <= sumsq + QW'(st.in_data) * QW'(st.in_data);
            cnt   <= last_accept ? '0 : cnt + 1'b1;
          end
        end
        CALC: begin
          variance <= var_next;
          rem      <= '0;
          root     <= '0;
          iter     <= '0;
        end
        SQRT: begin
          variance <= variance << 2;
          rem      <= rem_next;
          root     <= root_next;
          iter     <= iter + 1'b1;
        end
        DONE: begin
          // First DONE cycle registers the root; out_valid rises with it
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            std_dev_q   <= root;
          end else if (st.out_ready) begin
            out_valid_q <= 1'b0;
            cnt         <= '0;
            sum         <= '0;
            sumsq       <= '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef STD_DEV_MEAN_OUT_EN
  logic [SIZE-1:0] mean_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      mean_q <= '0;
    end else if (state == CALC) begin
      mean_q <= sum[SW-1:LG];
    end
  end

  assign st.mean_out = mean_q;
`endif

  assign st.in_ready  = in_ready_c;
  assign st.out_valid = out_valid_q;
  assign st.std_dev   = std_dev_q;
endmodule

// File: tb/tb_std_dev_stream.sv
// tb/tb_std_dev_stream.sv - directed self-checking bench for std_dev_stream
// Mean checks compile in only with STD_DEV_MEAN_OUT_EN.
module tb_std_dev_stream;
  localparam int N    = 8;
  localparam int SIZE = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  std_dev_stream_if #(.SIZE(SIZE)) bus ();

  std_dev_stream #(.N_INPUT(N), .SIZE(SIZE)) dut (
    .clk   (clk),
    .reset (reset),
    .st    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int lat;
  logic [31:0] vec [8];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Enters and leaves on a negedge except the final sample, which returns right after its accepting posedge
  task automatic send_set(input int nsamp, input bit gaps);
    for (int i = 0; i < nsamp; i++) begin
      if (gaps) begin
        int g;
        g = $urandom_range(0, 3);
        repeat (g) begin
          bus.in_valid = 1'b0;
          @(posedge clk);
          @(negedge clk);
        end
      end
      check_eq("in_ready_before_sample", bus.in_ready, 1);
      bus.in_valid = 1'b1;
      bus.in_data  = vec[i];
      @(posedge clk);
      if (i != nsamp - 1) @(negedge clk);
    end
  endtask

  task automatic wait_result(input string tag, output int cycles);
    cycles = 0;
    while (cycles < 200) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
      if (bus.out_valid) break;
    end
    if (!bus.out_valid) check_eq({tag, "_timeout"}, bus.out_valid, 1);
  endtask

  task automatic check_result(input string tag, input logic [31:0] exp_std, input logic [31:0] exp_mean);
    check_eq({tag, "_std_dev"}, bus.std_dev, exp_std);
`ifdef STD_DEV_MEAN_OUT_EN
    check_eq({tag, "_mean_out"}, bus.mean_out, exp_mean);
`else
    if (exp_mean == 32'hFFFF_FFFF) $display("note: %s unexpected mean marker", tag);
`endif
  endtask

  task automatic take_result(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check_eq({tag, "_in_ready_after_take"}, bus.in_ready, 1);
    check_eq({tag, "_out_valid_after_take"}, bus.out_valid, 0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("reset_in_ready", bus.in_ready, 1);
    check_eq("reset_out_valid", bus.out_valid, 0);
    check_eq("reset_std_dev", bus.std_dev, 0);
`ifdef STD_DEV_MEAN_OUT_EN
    check_eq("reset_mean_out", bus.mean_out, 0);
`endif
    reset = 1'b0;

    // Set 1: textbook set, in_valid kept high past the 8th sample
    vec = '{32'd2, 32'd4, 32'd4, 32'd4, 32'd5, 32'd5, 32'd7, 32'd9};
    send_set(8, 1'b0);
    @(negedge clk);
    check_eq("t1_in_ready_low", bus.in_ready, 0);
    bus.in_data = 32'd99;
    wait_result("t1", lat);
    check_eq("t1_latency", lat, 34);
    check_result("t1", 32'd2, 32'd5);
    bus.in_valid = 1'b0;
    take_result("t1");

    // Set 2: all equal
    vec = '{32'd7, 32'd7, 32'd7, 32'd7, 32'd7, 32'd7, 32'd7, 32'd7};
    send_set(8, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_result("t2", lat);
    check_result("t2", 32'd0, 32'd7);
    take_result("t2");

    // Set 3: full-width extremes
    vec = '{32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    send_set(8, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_result("t3", lat);
    check_result("t3", 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    take_result("t3");

    // Set 4: input gaps, then 10 cycles of output backpressure with junk offered on the input
    vec = '{32'd10, 32'd20, 32'd30, 32'd40, 32'd50, 32'd60, 32'd70, 32'd80};
    send_set(8, 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_result("t4", lat);
    check_result("t4", 32'd22, 32'd45);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hDEAD;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_eq("t4_hold_out_valid", bus.out_valid, 1);
      check_eq("t4_hold_std_dev", bus.std_dev, 22);
      check_eq("t4_hold_in_ready", bus.in_ready, 0);
    end
    bus.in_valid = 1'b0;
    take_result("t4");

    // Set 5: partial set aborted by reset, then a fresh set
    vec = '{32'd500, 32'd600, 32'd700, 32'd800, 32'd900, 32'd0, 32'd0, 32'd0};
    send_set(5, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_eq("t5_reset_in_ready", bus.in_ready, 1);
    check_eq("t5_reset_out_valid", bus.out_valid, 0);
    check_eq("t5_reset_std_dev", bus.std_dev, 0);
    vec = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd3, 32'd3, 32'd3, 32'd3};
    send_set(8, 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_result("t5", lat);
    check_result("t5", 32'd1, 32'd2);
    take_result("t5");

    // Set 6: two back-to-back sets with out_ready tied high
    bus.out_ready = 1'b1;
    vec = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd16};
    send_set(8, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_result("t6a", lat);
    check_result("t6a", 32'd5, 32'd2);
    @(posedge clk);
    @(negedge clk);
    check_eq("t6a_in_ready_after_take", bus.in_ready, 1);
    check_eq("t6a_out_valid_after_take", bus.out_valid, 0);
    vec = '{32'd100, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    send_set(8, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_result("t6b", lat);
    check_eq("t6b_latency", lat, 34);
    check_result("t6b", 32'd33, 32'd12);
    @(posedge clk);
    @(negedge clk);
    check_eq("t6b_in_ready_after_take", bus.in_ready, 1);
    check_eq("t6b_out_valid_after_take", bus.out_valid, 0);
    bus.out_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
